// File: rtl/eth_tx_pkg.sv
// Shared definitions for the Ethernet transmit path: scheduler state encoding,
// packet kind constants and the default payload/gap sizes.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitTx,
    StSend,
    StGap
  } sched_state_e;

  localparam logic PKT_JPEG = 1'b0;
  localparam logic PKT_STAT = 1'b1;

  localparam int unsigned PAYLOAD_BYTES_DEF = 1024;
  localparam int unsigned IFG_CYCLES_DEF    = 24;

  // Wide enough for both the start timeout and the inter-packet gap.
  localparam int unsigned TIMER_W = 16;

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter with a done flag; shared by the GAP and WAIT_TX phases.
module sched_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/jpeg_pkt_scheduler.sv
// Transmit packet scheduler: arbitrates JPEG payload vs status packets, issues a
// start pulse with a latched descriptor, and enforces start timeout and inter-packet gap.
module jpeg_pkt_scheduler
  import eth_tx_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = PAYLOAD_BYTES_DEF,
  parameter int unsigned STAT_BYTES    = 64,
  parameter int unsigned LVL_W         = 13,
  parameter int unsigned SEQ_W         = 16,
  parameter int unsigned IFG_CYCLES    = IFG_CYCLES_DEF,
  parameter int unsigned STARVE_LIMIT  = 4,
  parameter int unsigned START_TIMEOUT = 256
) (
  input  logic             eth_clk,
  input  logic             rst,
  input  logic [LVL_W-1:0] fifo_level,
  input  logic             frame_done,
  input  logic             stat_req,
  output logic             stat_ack,
  input  logic             tx_active,
  output logic             start_send,
  output logic             pkt_kind,
  output logic [LVL_W-1:0] pkt_len,
  output logic [SEQ_W-1:0] pkt_seq,
  output logic             pkt_last,
  output logic             tx_err,
  output logic             busy
);

  localparam int unsigned RunW = $clog2(STARVE_LIMIT + 1) + 1;
  localparam logic [LVL_W-1:0] PayLen  = LVL_W'(PAYLOAD_BYTES);
  localparam logic [LVL_W-1:0] StatLen = LVL_W'(STAT_BYTES);

  sched_state_e     state_q, state_d;
  logic [RunW-1:0]  jpeg_run_q, jpeg_run_d;
  logic             start_send_q, start_send_d;
  logic             stat_ack_q, stat_ack_d;
  logic             tx_err_q, tx_err_d;
  logic             busy_q, busy_d;
  logic             pkt_kind_q, pkt_kind_d;
  logic [LVL_W-1:0] pkt_len_q, pkt_len_d;
  logic [SEQ_W-1:0] pkt_seq_q, pkt_seq_d;
  logic             pkt_last_q, pkt_last_d;

  logic               jpeg_elig, any_elig, stat_win;
  logic               tmr_load, tmr_done;
  logic [TIMER_W-1:0] tmr_val;

  assign jpeg_elig = (fifo_level >= PayLen) || (frame_done && (fifo_level != '0));
  assign any_elig  = jpeg_elig || stat_req;
  assign stat_win  = stat_req && (!jpeg_elig || (jpeg_run_q >= RunW'(STARVE_LIMIT)));

  sched_timer #(
    .Width(TIMER_W)
  ) u_timer (
    .clk_i      (eth_clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge eth_clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      jpeg_run_q   <= '0;
      start_send_q <= 1'b0;
      stat_ack_q   <= 1'b0;
      tx_err_q     <= 1'b0;
      busy_q       <= 1'b0;
      pkt_kind_q   <= PKT_JPEG;
      pkt_len_q    <= '0;
      pkt_seq_q    <= '0;
      pkt_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      jpeg_run_q   <= jpeg_run_d;
      start_send_q <= start_send_d;
      stat_ack_q   <= stat_ack_d;
      tx_err_q     <= tx_err_d;
      busy_q       <= busy_d;
      pkt_kind_q   <= pkt_kind_d;
      pkt_len_q    <= pkt_len_d;
      pkt_seq_q    <= pkt_seq_d;
      pkt_last_q   <= pkt_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_elig) state_d = StStart;
      StStart:  state_d = StWaitTx;
      StWaitTx: begin
        if (tx_active) begin
          state_d = StSend;
        end else if (tmr_done) begin
          state_d = StGap;
        end
      end
      StSend:   if (!tx_active) state_d = StGap;
      StGap:    if (tmr_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Loads are offset so tx_err lands START_TIMEOUT cycles after start_send and
  // IDLE is reached exactly IFG_CYCLES cycles after GAP is entered.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_q == StStart) begin
      tmr_load = 1'b1;
      tmr_val  = TIMER_W'(START_TIMEOUT - 2);
    end else if ((state_q != StGap) && (state_d == StGap)) begin
      tmr_load = 1'b1;
      tmr_val  = TIMER_W'(IFG_CYCLES - 1);
    end
  end

  always_comb begin
    start_send_d = (state_q == StIdle) && any_elig;
    stat_ack_d   = start_send_d && stat_win;
    tx_err_d     = (state_q == StWaitTx) && !tx_active && tmr_done;
    busy_d       = (state_d != StIdle);
    jpeg_run_d   = jpeg_run_q;
    pkt_kind_d   = pkt_kind_q;
    pkt_len_d    = pkt_len_q;
    pkt_last_d   = pkt_last_q;
    pkt_seq_d    = pkt_seq_q;
    if (start_send_d) begin
      if (stat_win) begin
        pkt_kind_d = PKT_STAT;
        pkt_len_d  = StatLen;
        pkt_last_d = 1'b0;
        jpeg_run_d = '0;
      end else begin
        pkt_kind_d = PKT_JPEG;
        pkt_len_d  = (fifo_level > PayLen) ? PayLen : fifo_level;
        pkt_last_d = frame_done && (fifo_level <= PayLen);
        jpeg_run_d = stat_req ? jpeg_run_q + RunW'(1) : '0;
      end
    end
    if ((state_q == StSend) && !tx_active && (pkt_kind_q == PKT_JPEG)) begin
      pkt_seq_d = pkt_seq_q + SEQ_W'(1);
    end
  end

  assign start_send = start_send_q;
  assign stat_ack   = stat_ack_q;
  assign tx_err     = tx_err_q;
  assign busy       = busy_q;
  assign pkt_kind   = pkt_kind_q;
  assign pkt_len    = pkt_len_q;
  assign pkt_seq    = pkt_seq_q;
  assign pkt_last   = pkt_last_q;

endmodule
